rv_alu_arb: RTL and testbench
=============================

# rv_alu_arb

Two-port round-robin arbiter that shares the single-cycle RV_ALU between two requesters, e.g. core execute stage (port 0) and UART debug/command path (port 1). It accepts at most one operation per cycle and drives the operands and opcode onto the shared ALU. It captures the ALU result into a per-port response register and returns it with a valid/ready handshake. The ALU itself remains purely combinational and external to this block.

## Interface
Parameters:
- XLEN, 32, operand/result width; must match the ALU (32).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 has an operation.
- req0_ready  out  1  port 0 operation accepted this cycle when valid & ready.
- req0_a, req0_b  in  XLEN  port 0 operands.
- req0_op  in  4  port 0 ALU opcode ({inst[30], funct3} encoding).
- rsp0_valid  out  1  port 0 result available.
- rsp0_ready  in  1  port 0 consumes result.
- rsp0_result  out  XLEN  port 0 result register.
- req1_*, rsp1_*  same as port 0, for port 1.
- alu_a, alu_b  out  XLEN  operands to the shared ALU.
- alu_op  out  4  opcode to the shared ALU.
- alu_result  in  XLEN  combinational result from the shared ALU.

## Operation
- Per-port response slot: a 1-entry register (rspN_valid, rspN_result).
- slot_freeN = !rspN_valid | rspN_ready (drain and refill in the same cycle are allowed).
- eligibleN = reqN_valid & slot_freeN.
- Priority pointer prio (1 bit, reset 0) marks the port that wins when both are eligible.
- Grant:
  - If only one port is eligible, it wins.
  - If both are eligible, port prio wins.
  - If neither is eligible, there is no grant.
- reqN_ready = grantN. This is combinational from reqN_valid, rspN_valid and rspN_ready. A port whose slot is full and not draining sees ready=0.
- ALU mux:
  - alu_a/b/op = granted port's operands and op.
  - With no grant, they take port 0's inputs. This value is don't-care but deterministic, so no X reaches the ALU.
- On a grant at edge N:
  - rspN_result <= alu_result.
  - rspN_valid <= 1.
  - prio <= ~granted port. prio only changes on a contested or uncontested grant, never on idle cycles.
- Drain without refill (rspN_valid & rspN_ready & !grantN): rspN_valid <= 0. rspN_result holds its last value.
- Requesters must hold reqN_a/b/op stable while valid & !ready. The arbiter does not latch operands before grant.
- Each port receives its responses in its own request order. With a 1-deep slot and one op per port in flight, ordering is trivially preserved.

## Timing
- Reset (async assert, sync release at the next clk edge after rst falls):
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_result = rsp1_result = 0.
  - prio = 0.
  - reqN_ready forced to 0 while rst is high.
- Latency: a request accepted in cycle N has rspN_valid=1 in cycle N+1. Back-to-back on one port gives 1 op/cycle if rspN_ready is held high.
- Aggregate throughput: 1 ALU op/cycle. With both ports continuously eligible, grants alternate 0,1,0,1,...
- rspN_valid & !rspN_ready: result is held stable and no new grant goes to that port. The other port is unaffected.
- Reset mid-operation: pending responses are discarded. No grant occurs in the cycle rst is high.
- Combinational path: reqN_valid/rspN_ready -> grant -> alu_* -> alu_result -> rspN_result D input. The whole path must close at the system clock.

## Test plan
- Single op: port 0 sends A=5, B=3, op=4'b1000 (SUB). Expect req0_ready=1 in the same cycle, then rsp0_valid=1 and rsp0_result=2 in the next cycle. prio becomes 1.
- Contention: both ports valid from reset. Port 0 sends ADD 1+1; port 1 sends XOR 0xFF^0x0F. Expect port 0 granted first (prio=0), giving rsp0_result=2. Port 1 is granted next cycle, giving rsp1_result=0xF0. Further contention alternates grants.
- Backpressure: rsp1_ready=0 with rsp1_valid=1 and req1_valid=1. Expect req1_ready=0 and rsp1_result held. Port 0 streams SLL 1<<4 = 0x10 every cycle. Raising rsp1_ready lets port 1 be granted in that same cycle.
- Drain+refill: rsp0_ready=1 with a continuous port 0 stream of SLT signed -1<1. Expect rsp0_valid steady at 1, rsp0_result=1 each cycle, and no bubble.
- Async reset mid-stream: assert rst between edges while rsp0_valid=1. Expect rsp0_valid=0 immediately (before the next edge), ready=0 while rst is high, and prio=0 after release.
- Signed shift passthrough: port 1 sends SRA 0x80000000 >>> 4. Expect rsp1_result=0xF8000000, confirming operand and op routing to the ALU.

Source files
------------

// File: rtl/rv_alu_arb.sv
// Two-port round-robin arbiter sharing one combinational RV ALU.
// Each port has a single-entry response register with valid/ready handshake.
module rv_alu_arb #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [3:0]      req0_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [3:0]      req1_op,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result
);

    logic            prio_q, prio_d;
    logic            rsp0_valid_q, rsp0_valid_d;
    logic            rsp1_valid_q, rsp1_valid_d;
    logic [XLEN-1:0] rsp0_result_q, rsp0_result_d;
    logic [XLEN-1:0] rsp1_result_q, rsp1_result_d;

    logic elig0, elig1;
    logic grant0, grant1;

    // A full slot that is draining this cycle may be refilled in the same cycle.
    assign elig0 = !rst && req0_valid && (!rsp0_valid_q || rsp0_ready);
    assign elig1 = !rst && req1_valid && (!rsp1_valid_q || rsp1_ready);

    assign grant0 = elig0 && (!elig1 || !prio_q);
    assign grant1 = elig1 && (!elig0 ||  prio_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Idle cycles still present port 0's operands so the ALU never sees X.
    always_comb begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
        if (grant1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    always_comb begin
        prio_d        = prio_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;

        if (grant0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
        end else if (rsp0_ready) begin
            rsp0_valid_d  = 1'b0;
        end

        if (grant1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
        end else if (rsp1_ready) begin
            rsp1_valid_d  = 1'b0;
        end

        if (grant0) begin
            prio_d = 1'b1;
        end else if (grant1) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q        <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
        end else begin
            prio_q        <= prio_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;

endmodule

// File: tb/tb_rv_alu_arb.sv
// Bench for rv_alu_arb: provides the shared ALU, a transaction-level model
// compared every cycle, and directed scenarios with literal expectations.
module tb_rv_alu_arb;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic            req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]      req0_op, req1_op, alu_op;
    logic [XLEN-1:0] rsp0_result, rsp1_result;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv_alu_arb #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
    );

    // RV32 ALU, opcode = {inst[30], funct3}
    function automatic logic [XLEN-1:0] alu_f(logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                                              logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'd0, $signed(a) < $signed(b)};
            4'b0011: return {31'd0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one slot per port plus the round-robin pointer.
    logic            m_v0, m_v1, m_prio;
    logic [XLEN-1:0] m_r0, m_r1;

    function automatic logic [1:0] exp_grant();
        logic e0, e1;
        e0 = req0_valid && (!m_v0 || rsp0_ready);
        e1 = req1_valid && (!m_v1 || rsp1_ready);
        if (rst) return 2'b00;
        if (e0 && e1) return m_prio ? 2'b10 : 2'b01;
        return {e1, e0};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v0 <= 1'b0; m_v1 <= 1'b0; m_prio <= 1'b0;
            m_r0 <= '0;   m_r1 <= '0;
        end else begin
            logic [1:0] g;
            g = exp_grant();
            if (g[0]) begin
                m_v0 <= 1'b1; m_r0 <= alu_f(req0_a, req0_b, req0_op);
            end else if (rsp0_ready) m_v0 <= 1'b0;
            if (g[1]) begin
                m_v1 <= 1'b1; m_r1 <= alu_f(req1_a, req1_b, req1_op);
            end else if (rsp1_ready) m_v1 <= 1'b0;
            if (g[0]) m_prio <= 1'b1;
            else if (g[1]) m_prio <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [1:0] g;
            g = exp_grant();
            check("model req0_ready", {31'd0, req0_ready}, {31'd0, g[0]});
            check("model req1_ready", {31'd0, req1_ready}, {31'd0, g[1]});
            check("model rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_v0});
            check("model rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_v1});
            check("model rsp0_result", rsp0_result, m_r0);
            check("model rsp1_result", rsp1_result, m_r1);
            check("model alu_a", alu_a, g[1] ? req1_a : req0_a);
            check("model alu_op", {28'd0, alu_op}, {28'd0, g[1] ? req1_op : req0_op});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1;    req0_b = 32'd1;    req0_op = 4'b0000;
        req1_valid = 1'b1; req1_a = 32'hFF;   req1_b = 32'h0F;   req1_op = 4'b0100;
        repeat (2) @(posedge clk);
        #1;
        check("reset req0_ready", {31'd0, req0_ready}, 32'd0);
        check("reset req1_ready", {31'd0, req1_ready}, 32'd0);
        check("reset rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("reset rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check("reset rsp0_result", rsp0_result, 32'd0);
        check("reset rsp1_result", rsp1_result, 32'd0);
        rst = 1'b0;
        #1;
        check("contend first req0_ready", {31'd0, req0_ready}, 32'd1);
        check("contend first req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        check("contend add rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("contend add rsp0_result", rsp0_result, 32'd2);
        check("contend second req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        check("contend xor rsp1_result", rsp1_result, 32'hF0);
        check("contend xor rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        check("contend rsp0 drained", {31'd0, rsp0_valid}, 32'd0);
        check("contend third req0_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // single op with port 1 idle; pointer currently favours port 1
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b1000;
        #1;
        check("single req0_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        check("single rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("single rsp0_result", rsp0_result, 32'd2);

        // pointer now 1: port 1 wins contention
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0000;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 4'b0000;
        rsp1_ready = 1'b0;
        #1;
        check("prio1 req1_ready", {31'd0, req1_ready}, 32'd1);
        check("prio1 req0_ready", {31'd0, req0_ready}, 32'd0);
        tick();

        // backpressure on port 1 while port 0 streams SLL
        req1_a = 32'd7; req1_b = 32'd8;
        req0_a = 32'd1; req0_b = 32'd4; req0_op = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp req1_ready", {31'd0, req1_ready}, 32'd0);
            check("bp req0_ready", {31'd0, req0_ready}, 32'd1);
            tick();
            check("bp rsp1_result held", rsp1_result, 32'd4);
            check("bp rsp1_valid held", {31'd0, rsp1_valid}, 32'd1);
            check("bp rsp0_result", rsp0_result, 32'h10);
        end
        rsp1_ready = 1'b1;
        #1;
        check("bp release req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        check("bp release rsp1_result", rsp1_result, 32'd15);
        req1_valid = 1'b0;

        // drain and refill on port 0 with no bubble
        req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            check("stream rsp0_result", rsp0_result, 32'd1);
        end

        // asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        check("async rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("async rsp0_result", rsp0_result, 32'd0);
        check("async req0_ready", {31'd0, req0_ready}, 32'd0);
        tick();
        rst = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3; req1_op = 4'b0000;
        #1;
        check("post reset req0_ready", {31'd0, req0_ready}, 32'd1);
        check("post reset req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // arithmetic shift routed from port 1
        req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'd4; req1_op = 4'b1101;
        tick();
        req1_valid = 1'b0;
        check("sra rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        check("sra rsp1_result", rsp1_result, 32'hF800_0000);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
